// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: address/data widths and the queued
// ALU-result entry.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_queue.sv
// In-order FIFO of pending ALU register writes. Also reports whether any
// occupied entry targets either read address, so issue can stall on it.
module wb_result_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] din_rd_i,
    input  logic [XLEN-1:0]   din_data_i,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [XLEN-1:0]   head_data_o,
    output logic              full_o,
    output logic              empty_o,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_hit_o,
    output logic              rs2_hit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          entries_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;
    logic [PTR_W-1:0]   offs;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_rd_o   = entries_q[rd_ptr_q].rd;
    assign head_data_o = entries_q[rd_ptr_q].data;

    // Pointers are PTR_W wide, so the modulo-DEPTH wrap comes for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= '{rd: din_rd_i, data: din_data_i};
        end
    end

    // An entry is occupied when its distance from the read pointer is below count.
    always_comb begin
        rs1_hit_o = 1'b0;
        rs2_hit_o = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offs} < count_q) begin
                if (entries_q[i].rd == rs1_addr_i) rs1_hit_o = 1'b1;
                if (entries_q[i].rd == rs2_addr_i) rs2_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: arbitrates memory/ALU writes into the integer register file
// and serves two bypassed read ports. RISCAT_WB_RETIRE_CNT_EN adds retire_cnt.
module wb_regfile_stage
    import wb_pkg::ADDR_W;
#(
    parameter int QDEPTH = 2,
    parameter int XLEN   = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_wr_en,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_rd,
    output logic [XLEN-1:0]   commit_data
`ifdef RISCAT_WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic              accept, q_push, q_pop, q_full, q_empty;
    logic              rs1_hit, rs2_hit, mem_sel, wr_en;
    logic [ADDR_W-1:0] head_rd, wr_rd;
    logic [XLEN-1:0]   head_data, wr_data;
    logic              commit_valid_q;
    logic [ADDR_W-1:0] commit_rd_q;
    logic [XLEN-1:0]   commit_data_q;

    assign ex_ready = !q_full;
    assign accept   = ex_valid && ex_ready;
    assign q_push   = accept && ex_wr_en && (ex_rd != '0);
    // Any mem_valid cycle holds the queue head, even one that writes nothing.
    assign mem_sel  = mem_valid && (mem_rd != '0);
    assign q_pop    = !mem_valid && !q_empty;
    assign wr_en    = mem_sel || q_pop;
    assign wr_rd    = mem_sel ? mem_rd   : head_rd;
    assign wr_data  = mem_sel ? mem_data : head_data;

    wb_result_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (q_push),
        .pop_i      (q_pop),
        .din_rd_i   (ex_rd),
        .din_data_i (ex_result),
        .head_rd_o  (head_rd),
        .head_data_o(head_data),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_hit_o  (rs1_hit),
        .rs2_hit_o  (rs2_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en && (wr_rd != '0)) begin
            regs_q[wr_rd] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0)                   rs1_data = '0;
        else if (wr_en && (wr_rd == rs1_addr)) rs1_data = wr_data;
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0)                   rs2_data = '0;
        else if (wr_en && (wr_rd == rs2_addr)) rs2_data = wr_data;
    end

    assign rs1_busy = rs1_hit && (rs1_addr != '0);
    assign rs2_busy = rs2_hit && (rs2_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
        end else begin
            commit_valid_q <= wr_en;
            if (wr_en) begin
                commit_rd_q   <= wr_rd;
                commit_data_q <= wr_data;
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;

`ifdef RISCAT_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // Dropped (wr_en=0 / x0) pushes still retire an instruction.
    assign retire_cnt_d = retire_cnt_q + 64'(accept) + 64'(mem_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retire_cnt_q <= '0;
        else          retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
Writeback end of the EX->WB interface. It consumes ALU results leaving the execute stage and load data returning from memory, and arbitrates one register-file write per cycle. It owns the 32x32 integer register file and serves the two operand read ports used by the execute stage. A small in-order queue absorbs ALU results while memory writeback has priority, and a per-source busy flag lets issue stall on pending writes.

Parameters:
QDEPTH, 2, ALU result queue depth (power of two, >=2)
XLEN, 32, data width
NREGS, 32, architectural registers; address width = $clog2(NREGS)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
ex_valid  in  1  ALU result present (EX_WB alu_result_ready)
ex_ready  out  1  queue can accept; = !full, combinational from registered state only
ex_rd  in  5  destination register (EX_WB reg_wr_addr)
ex_wr_en  in  1  register write enable (EX_WB reg_wr_en)
ex_result  in  XLEN  ALU result (EX_WB alu_result)
mem_valid  in  1  load data returning; never stalled
mem_rd  in  5  load destination
mem_data  in  XLEN  load data
rs1_addr, rs2_addr  in  5  read addresses
rs1_data, rs2_data  out  XLEN  combinational read data with same-cycle write bypass
rs1_busy, rs2_busy  out  1  queued, unwritten ALU result targets that register
commit_valid  out  1  registered: a register write happened last cycle
commit_rd  out  5  registered address of that write
commit_data  out  XLEN  registered data of that write

Behaviour:
- Reset (async, reset_n low): all registers = 0, queue empty, commit_valid/commit_rd/commit_data = 0. ex_ready = 1 while in reset and after it. Reset mid-operation discards queued results; no write occurs.
- Accept: push on the rising edge when ex_valid && ex_ready. Entries with ex_wr_en=0 or ex_rd=0 are accepted but not enqueued; they are counted as retired (see optional feature).
- Full: ex_ready = 0 when count == QDEPTH, even if a pop occurs the same cycle. There is no same-cycle refill of a full queue.
- Write arbitration, one write per cycle:
  - If mem_valid and mem_rd != 0: write mem_data. The queue head is held.
  - Else if the queue is non-empty: pop the head and write it.
  - mem_valid with mem_rd = 0 consumes the cycle but writes nothing. commit_valid = 0 for it, and the queue is still held.
- Latency: an ALU result accepted at edge N is written at edge N+1 with no memory contention. Each contending mem_valid cycle adds one cycle.
- Empty queue with no mem_valid: no write, commit_valid = 0 next cycle.
- x0: never written, reads always 0, never busy.
- Read: rsX_data = 0 if rsX_addr = 0. Else, if this cycle's selected write targets rsX_addr, return the write data (bypass). Else return the register-file contents.
- Busy: rsX_busy = 1 if any valid queue entry has rd == rsX_addr != 0. A head popped this cycle still counts busy (registered queue state), but its bypass data is valid.
- Ordering: the hazard unit guarantees no in-flight memory and ALU writes to the same rd at once. The block need not order them.
- Pointers wrap modulo QDEPTH. count is held in $clog2(QDEPTH)+1 bits.

Optional Feature:
RISCAT_WB_RETIRE_CNT_EN
- Defined: adds an output retire_cnt (64 bits, reset 0). It increments by 1 per ALU push (including dropped wr_en=0/x0 entries) and per mem_valid cycle. When both occur in the same cycle it increments by 2. It wraps at 2^64.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_pkg: ADDR_W, XLEN, and a wb_entry_t struct {rd, data}.
- The EX_WB struct stays in the pipeline-register definitions; the parent unpacks its fields onto these ports.
- Sub-module wb_result_queue: the FIFO with push/pop/count and per-entry rd compare outputs for busy detection.
- Register-file array, arbitration and bypass logic stay in the top module.

Test Plan:
- ALU write: push rd=5, result 0x12345678, no mem. rs1_addr=5 reads 0x12345678 via bypass in cycle N+1 and from the register file thereafter. commit_valid=1, rd=5 at N+2.
- Memory priority: push rd=3 (0xAAAA0000) and hold mem_valid rd=7 (0xBEEF) for 2 cycles.
  - r7 is written first; r3 is written the cycle after mem_valid drops.
  - rs1_busy (rs1_addr=3) stays 1 until r3's write cycle.
- Backpressure, QDEPTH=2: hold mem_valid and push 3 results. ex_ready drops after 2 accepts, the third is held at its source, and all three are written in order after memory releases.
- x0: push rd=0 result 0xFFFFFFFF, and mem_valid rd=0. r0 reads 0, commit_valid stays 0, and busy is never asserted.
- Async reset with 2 entries queued: all registers read 0, ex_ready=1, commit_valid=0, and no queued write appears after reset release.
- With RISCAT_WB_RETIRE_CNT_EN: 4 pushes (one with wr_en=0) plus 2 mem cycles, one of them simultaneous with a push, gives retire_cnt=6.
